// File: rtl/ysyx_22040759_exu_alu_pkg.sv
// ysyx_22040759_exu_alu_pkg: op codes, FSM states and op classification for the EX ALU
package ysyx_22040759_exu_alu_pkg;
  localparam logic [3:0] alu_add   = 4'd0;
  localparam logic [3:0] alu_sub   = 4'd1;
  localparam logic [3:0] alu_or    = 4'd2;
  localparam logic [3:0] alu_sltiu = 4'd3;
  localparam logic [3:0] alu_and   = 4'd4;
  localparam logic [3:0] alu_xor   = 4'd5;
  localparam logic [3:0] alu_slt   = 4'd6;
  localparam logic [3:0] alu_sll   = 4'd7;
  localparam logic [3:0] alu_srl   = 4'd8;
  localparam logic [3:0] alu_sra   = 4'd9;
  localparam logic [3:0] alu_mul   = 4'd10;
  localparam logic [3:0] alu_mulhu = 4'd11;
  localparam logic [3:0] alu_divu  = 4'd12;
  localparam logic [3:0] alu_remu  = 4'd13;
  typedef enum logic [1:0] {st_idle, st_busy, st_done} alu_state_e;
  function automatic logic is_div(input logic [3:0] sel);
    return sel == alu_divu || sel == alu_remu;
  endfunction
  function automatic logic is_iter(input logic [3:0] sel);
    return sel == alu_mul || sel == alu_mulhu || is_div(sel);
  endfunction
  function automatic logic wants_hi(input logic [3:0] sel);
    return sel == alu_mulhu || sel == alu_remu;
  endfunction
endpackage

// File: rtl/ysyx_22040759_alu_iter.sv
// ysyx_22040759_alu_iter: shared radix-2 shift-add multiplier and restoring divider
module ysyx_22040759_alu_iter
  import ysyx_22040759_exu_alu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            kill,
  input  logic            start,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN) + 1;
  logic [XLEN-1:0] hi, lo, m, hi_n, lo_n;
  logic [3:0]      op_q;
  logic [CW-1:0]   cnt;
  logic [XLEN:0]   sum, rs;
  logic [XLEN+1:0] diff;
  // hi:lo is the product accumulator for mul, remainder:quotient for divide
  always_comb begin
    sum  = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
    rs   = {hi, lo[XLEN-1]};
    diff = {1'b0, rs} - {2'b0, m};
    hi_n = is_div(op_q) ? (diff[XLEN+1] ? rs[XLEN-1:0] : diff[XLEN-1:0]) : sum[XLEN:1];
    lo_n = is_div(op_q) ? {lo[XLEN-2:0], ~diff[XLEN+1]} : {sum[0], lo[XLEN-1:1]};
  end
  assign done   = cnt == CW'(1);
  assign result = wants_hi(op_q) ? hi_n : lo_n;
  always_ff @(posedge clk) begin
    if (rst || kill) begin
      cnt  <= '0;
      hi   <= '0;
      lo   <= '0;
      m    <= '0;
      op_q <= '0;
    end else if (start) begin
      cnt  <= CW'(XLEN);
      hi   <= '0;
      lo   <= is_div(op) ? a : b;
      m    <= is_div(op) ? b : a;
      op_q <= op;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
      hi  <= hi_n;
      lo  <= lo_n;
    end
  end
endmodule

// File: rtl/ysyx_22040759_exu_alu.sv
// ysyx_22040759_exu_alu: handshaked EX-stage ALU with single-cycle ops and iterative mul/div
module ysyx_22040759_exu_alu
  import ysyx_22040759_exu_alu_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] alu_a,
  input  logic [XLEN-1:0] alu_b,
  input  logic [3:0]      alu_sel,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_result
);
  alu_state_e      state;
  logic            accept, iter_op, it_done;
  logic [XLEN-1:0] sc_res, it_res;
  assign in_ready = !rst && !flush && (state == st_idle || (state == st_done && out_ready));
  assign accept   = in_valid && in_ready;
  // divide by zero has a fixed answer, so it bypasses the iterative unit
  assign iter_op  = is_iter(alu_sel) && !(is_div(alu_sel) && alu_b == '0);
  always_comb begin
    sc_res = '0;
    case (alu_sel)
      alu_add:   sc_res = alu_a + alu_b;
      alu_sub:   sc_res = alu_a - alu_b;
      alu_or:    sc_res = alu_a | alu_b;
      alu_sltiu: sc_res = XLEN'(alu_a < alu_b);
      alu_and:   sc_res = alu_a & alu_b;
      alu_xor:   sc_res = alu_a ^ alu_b;
      alu_slt:   sc_res = XLEN'($signed(alu_a) < $signed(alu_b));
      alu_sll:   sc_res = alu_a << alu_b[SHW-1:0];
      alu_srl:   sc_res = alu_a >> alu_b[SHW-1:0];
      alu_sra:   sc_res = XLEN'($signed(alu_a) >>> alu_b[SHW-1:0]);
      alu_divu:  sc_res = '1;
      alu_remu:  sc_res = alu_a;
      default:   sc_res = '0;
    endcase
  end
  ysyx_22040759_alu_iter #(.XLEN(XLEN)) u_iter (
    .clk    (clk),
    .rst    (rst),
    .kill   (flush),
    .start  (accept && iter_op),
    .op     (alu_sel),
    .a      (alu_a),
    .b      (alu_b),
    .done   (it_done),
    .result (it_res)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= st_idle;
      out_valid  <= 1'b0;
      alu_result <= '0;
    end else if (flush) begin
      state     <= st_idle;
      out_valid <= 1'b0;
    end else if (accept) begin
      state     <= iter_op ? st_busy : st_done;
      out_valid <= !iter_op;
      if (!iter_op) alu_result <= sc_res;
    end else if (state == st_busy && it_done) begin
      state      <= st_done;
      out_valid  <= 1'b1;
      alu_result <= it_res;
    end else if (state == st_done && out_ready) begin
      state     <= st_idle;
      out_valid <= 1'b0;
    end
  end
endmodule
